fml_burst_reader: RTL

//  FML initiator (read-only DMA) fetching a linear region from SDRAM via the memory controller's FML 4x32 port.

---
 rtl/hpdmc_pkg.sv | 19 +
 rtl/fml_burst_fifo.sv | 67 ++++++
 rtl/fml_burst_reader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hpdmc_pkg.sv
// Shared FML definitions for the SDRAM controller's 4x32 initiator ports.
// Contents: burst geometry (beats per burst, beat width, bytes per burst)
// and the state encoding of the burst reader FSM.
package hpdmc_pkg;

  localparam int FML_BURST_LEN   = 4;
  localparam int FML_BEAT_W      = 32;
  localparam int FML_BURST_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_REQ   = 3'd2,
    S_WDATA = 3'd3,
    S_BEATS = 3'd4,
    S_FIN   = 3'd5
  } fml_state_e;

endpackage

// File: rtl/fml_burst_fifo.sv
// Synchronous first-word-fall-through FIFO buffering FML read beats.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   push, din          : write one word (caller guarantees space)
//   pop                : consume head word; ignored when empty
//   flush              : discard all contents (takes priority)
//   dout, valid        : head word and its valid flag
//   level              : occupancy in words, 0..2**LOG2
module fml_burst_fifo #(
  parameter int W    = 32,
  parameter int LOG2 = 5
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [LOG2:0] level
);

  localparam int DEPTH = 2 ** LOG2;
  localparam logic [LOG2:0] DEPTH_W = (LOG2 + 1)'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [LOG2-1:0] wr_ptr;
  logic [LOG2-1:0] rd_ptr;
  logic [LOG2:0]   count;
  logic            do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign dout   = mem[rd_ptr];
  assign level  = count;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // The reader only issues a burst when four free slots exist.
  push_when_full: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                                   !(push && (count == DEPTH_W)));

endmodule

// File: rtl/fml_burst_reader.sv
// Read-only FML initiator: fetches nbursts_i consecutive 16-byte bursts
// starting at base_adr_i and streams the words out through a FWFT FIFO.
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   start_i, abort_i          : transfer control pulses
//   base_adr_i, nbursts_i     : transfer region, sampled at start
//   busy_o, done_o            : transfer active / one-cycle completion pulse
//   fml_*                     : FML 4x32 initiator port (read only)
//   q_data_o/q_valid_o/q_ready_i : word stream out, level_o FIFO occupancy
module fml_burst_reader
  import hpdmc_pkg::*;
#(
  parameter int ADR_W     = 25,
  parameter int FIFO_LOG2 = 5,
  parameter int CNT_W     = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADR_W-1:0]      base_adr_i,
  input  logic [CNT_W-1:0]      nbursts_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADR_W-1:0]      fml_adr,
  output logic                  fml_stb,
  output logic                  fml_we,
  output logic [3:0]            fml_sel,
  output logic [FML_BEAT_W-1:0] fml_di,
  input  logic                  fml_eack,
  input  logic                  fml_ack,
  input  logic [FML_BEAT_W-1:0] fml_do,
  output logic [FML_BEAT_W-1:0] q_data_o,
  output logic                  q_valid_o,
  input  logic                  q_ready_i,
  output logic [FIFO_LOG2:0]    level_o
);

  localparam logic [FIFO_LOG2:0] DEPTH_W = (FIFO_LOG2 + 1)'(2 ** FIFO_LOG2);
  localparam logic [FIFO_LOG2:0] BURST_W = (FIFO_LOG2 + 1)'(FML_BURST_LEN);

  fml_state_e         state_q, state_d;
  logic [ADR_W-1:0]   adr_q;
  logic [CNT_W-1:0]   rem_q;
  logic [1:0]         beat_q;
  logic               busy_q;
  logic               done_q;
  logic               abort_pend_q;

  logic               abort_now;
  logic               start_acc;
  logic               burst_end;
  logic               push;
  logic               flush;
  logic [FIFO_LOG2:0] level;
  logic [FIFO_LOG2:0] free;
  logic               space_ok;

  // Only one burst is ever in flight and ISSUE is entered after its last
  // beat has landed, so occupancy alone gives the free space.
  assign free      = DEPTH_W - level;
  assign space_ok  = (free >= BURST_W);
  assign abort_now = abort_pend_q | abort_i;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    burst_end = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = (nbursts_i == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_now)     state_d = S_FIN;
        else if (space_ok) state_d = S_REQ;
      end
      // Strobe must stay up until eack even if an abort arrives.
      S_REQ: begin
        if (fml_eack) state_d = S_WDATA;
      end
      S_WDATA: begin
        if (fml_ack) begin
          push    = 1'b1;
          state_d = S_BEATS;
        end
      end
      // Beats 1..3 follow the ack on consecutive cycles without handshake.
      S_BEATS: begin
        push = 1'b1;
        if (beat_q == 2'd3) begin
          burst_end = 1'b1;
          state_d   = ((rem_q == CNT_W'(1)) || abort_now) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN: begin
        flush   = abort_pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      rem_q        <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIN);

      if (state_q == S_FIN) busy_q <= 1'b0;
      else if (start_acc)   busy_q <= 1'b1;

      if (state_q == S_FIN)                        abort_pend_q <= 1'b0;
      else if (state_q != S_IDLE && abort_i)       abort_pend_q <= 1'b1;

      if (start_acc) begin
        adr_q <= base_adr_i & ~ADR_W'(4'hF);
        rem_q <= nbursts_i;
      end else if (burst_end) begin
        adr_q <= adr_q + ADR_W'(FML_BURST_BYTES);
        rem_q <= rem_q - 1'b1;
      end

      if (state_q == S_WDATA && fml_ack) beat_q <= 2'd1;
      else if (state_q == S_BEATS)       beat_q <= beat_q + 1'b1;
    end
  end

  fml_burst_fifo #(
    .W    (FML_BEAT_W),
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .din       (fml_do),
    .pop       (q_ready_i),
    .flush     (flush),
    .dout      (q_data_o),
    .valid     (q_valid_o),
    .level     (level)
  );

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fml_adr = adr_q;
  assign fml_stb = (state_q == S_REQ);
  assign fml_we  = 1'b0;
  assign fml_sel = 4'hF;
  assign fml_di  = '0;
  assign level_o = level;

endmodule
